// File: rtl/arf_rat.sv
// Architectural register file plus register alias table: renames destinations at dispatch,
// commits values at retire, and answers two source lookups with a same-cycle retire bypass.
module arf_rat #(
  parameter int N_ARF_REGS     = 32,
  parameter int REG_DATA_WIDTH = 32,
  parameter int ROB_ID_WIDTH   = 4,
  parameter int ARF_ID_WIDTH   = $clog2(N_ARF_REGS)
) (
  input  logic                      clk,
  input  logic                      rst_aH,
  input  logic                      dispatch_valid,
  input  logic                      dispatch_ready,
  input  logic                      dispatch_dst_valid,
  input  logic [ARF_ID_WIDTH-1:0]   dispatch_dst_arf_id,
  input  logic [ROB_ID_WIDTH-1:0]   dispatch_rob_id,
  input  logic [ARF_ID_WIDTH-1:0]   src1_arf_id,
  input  logic [ARF_ID_WIDTH-1:0]   src2_arf_id,
  output logic                      src1_busy,
  output logic                      src2_busy,
  output logic [ROB_ID_WIDTH-1:0]   src1_rob_id,
  output logic [ROB_ID_WIDTH-1:0]   src2_rob_id,
  output logic [REG_DATA_WIDTH-1:0] src1_data,
  output logic [REG_DATA_WIDTH-1:0] src2_data,
  input  logic                      retire,
  input  logic [ROB_ID_WIDTH-1:0]   retire_rob_id,
  input  logic [ARF_ID_WIDTH-1:0]   retire_arf_id,
  input  logic [REG_DATA_WIDTH-1:0] retire_reg_data,
  input  logic                      flush
);

  logic [REG_DATA_WIDTH-1:0] arf_data   [N_ARF_REGS];
  logic                      rat_busy   [N_ARF_REGS];
  logic [ROB_ID_WIDTH-1:0]   rat_rob_id [N_ARF_REGS];

  // Handshake: a dispatch takes effect only when dispatch_valid and dispatch_ready are both
  // high at the rising edge; this block never pushes back, so it has no ready of its own.
  logic dispatch_fire;
  logic rename_en;
  logic retire_en;

  assign dispatch_fire = dispatch_valid & dispatch_ready;
  assign rename_en     = dispatch_fire & dispatch_dst_valid & (dispatch_dst_arf_id != '0) & ~flush;
  assign retire_en     = retire & (retire_arf_id != '0);

  // Rename is applied after the retire clear so a same-register dispatch wins.
  always_ff @(posedge clk or posedge rst_aH) begin
    if (rst_aH) begin
      for (int i = 0; i < N_ARF_REGS; i++) begin
        arf_data[i]   <= '0;
        rat_busy[i]   <= 1'b0;
        rat_rob_id[i] <= '0;
      end
    end else begin
      if (flush) begin
        for (int i = 0; i < N_ARF_REGS; i++) rat_busy[i] <= 1'b0;
      end
      if (retire_en) begin
        arf_data[retire_arf_id] <= retire_reg_data;
        if (!flush && rat_busy[retire_arf_id] && (rat_rob_id[retire_arf_id] == retire_rob_id))
          rat_busy[retire_arf_id] <= 1'b0;
      end
      if (rename_en) begin
        rat_busy[dispatch_dst_arf_id]   <= 1'b1;
        rat_rob_id[dispatch_dst_arf_id] <= dispatch_rob_id;
      end
    end
  end

  logic [ARF_ID_WIDTH-1:0]   src_id   [2];
  logic                      lk_busy  [2];
  logic [ROB_ID_WIDTH-1:0]   lk_rob   [2];
  logic [REG_DATA_WIDTH-1:0] lk_data  [2];

  assign src_id[0] = src1_arf_id;
  assign src_id[1] = src2_arf_id;

  // Lookups see pre-edge state; a retiring youngest producer is forwarded directly.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      lk_busy[p] = 1'b0;
      lk_rob[p]  = '0;
      lk_data[p] = '0;
      if (!rst_aH && (src_id[p] != '0)) begin
        lk_rob[p] = rat_rob_id[src_id[p]];
        if (rat_busy[src_id[p]] && retire && (rat_rob_id[src_id[p]] == retire_rob_id)
            && (retire_arf_id == src_id[p])) begin
          lk_data[p] = retire_reg_data;
        end else if (rat_busy[src_id[p]]) begin
          lk_busy[p] = 1'b1;
          lk_data[p] = arf_data[src_id[p]];
        end else begin
          lk_data[p] = arf_data[src_id[p]];
        end
      end
    end
  end

  assign src1_busy   = lk_busy[0];
  assign src2_busy   = lk_busy[1];
  assign src1_rob_id = lk_rob[0];
  assign src2_rob_id = lk_rob[1];
  assign src1_data   = lk_data[0];
  assign src2_data   = lk_data[1];

endmodule

// File: tb/tb_arf_rat.sv
// Directed bench for arf_rat: a per-cycle compare against a register-level model of the
// rename/retire rules, plus hand-computed literal expectations for each scenario.
module tb_arf_rat;

  localparam int N  = 32;
  localparam int DW = 32;
  localparam int RW = 4;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_aH = 1'b1;
  logic          dispatch_valid, dispatch_ready, dispatch_dst_valid;
  logic [AW-1:0] dispatch_dst_arf_id;
  logic [RW-1:0] dispatch_rob_id;
  logic [AW-1:0] src1_arf_id, src2_arf_id;
  logic          src1_busy, src2_busy;
  logic [RW-1:0] src1_rob_id, src2_rob_id;
  logic [DW-1:0] src1_data, src2_data;
  logic          retire;
  logic [RW-1:0] retire_rob_id;
  logic [AW-1:0] retire_arf_id;
  logic [DW-1:0] retire_reg_data;
  logic          flush;

  int n_checks = 0;
  int n_pass   = 0;

  arf_rat dut (
    .clk(clk), .rst_aH(rst_aH),
    .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
    .dispatch_dst_valid(dispatch_dst_valid), .dispatch_dst_arf_id(dispatch_dst_arf_id),
    .dispatch_rob_id(dispatch_rob_id),
    .src1_arf_id(src1_arf_id), .src2_arf_id(src2_arf_id),
    .src1_busy(src1_busy), .src2_busy(src2_busy),
    .src1_rob_id(src1_rob_id), .src2_rob_id(src2_rob_id),
    .src1_data(src1_data), .src2_data(src2_data),
    .retire(retire), .retire_rob_id(retire_rob_id), .retire_arf_id(retire_arf_id),
    .retire_reg_data(retire_reg_data), .flush(flush)
  );

  // clock / reset
  always #5 clk = ~clk;

  // model: what each architectural register holds and who (if anyone) will produce it next
  logic [DW-1:0] m_val  [N];
  logic          m_pend [N];
  logic [RW-1:0] m_prod [N];

  always @(posedge clk or posedge rst_aH) begin
    if (rst_aH) begin
      for (int i = 0; i < N; i++) begin
        m_val[i] = '0; m_pend[i] = 1'b0; m_prod[i] = '0;
      end
    end else begin
      logic          ren;
      logic [AW-1:0] d;
      ren = dispatch_valid && dispatch_ready && dispatch_dst_valid && dispatch_dst_arf_id != 0;
      d   = dispatch_dst_arf_id;
      if (retire && retire_arf_id != 0) begin
        m_val[retire_arf_id] = retire_reg_data;
        if (m_pend[retire_arf_id] && m_prod[retire_arf_id] == retire_rob_id)
          m_pend[retire_arf_id] = 1'b0;
      end
      if (flush) begin
        for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
      end else if (ren) begin
        m_pend[d] = 1'b1;
        m_prod[d] = dispatch_rob_id;
      end
    end
  end

  task automatic expect_lookup(input logic [AW-1:0] id, output logic eb,
                               output logic [RW-1:0] er, output logic [DW-1:0] ed);
    eb = 1'b0; er = '0; ed = '0;
    if (!rst_aH && id != 0) begin
      er = m_prod[id];
      if (m_pend[id] && retire && retire_arf_id == id && retire_rob_id == m_prod[id])
        ed = retire_reg_data;
      else begin
        eb = m_pend[id];
        ed = m_val[id];
      end
    end
  endtask

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // scoreboard compare on every falling edge
  always @(negedge clk) begin
    logic eb; logic [RW-1:0] er; logic [DW-1:0] ed;
    expect_lookup(src1_arf_id, eb, er, ed);
    chk("cmp_src1_busy", {31'b0, src1_busy}, {31'b0, eb});
    chk("cmp_src1_data", src1_data, ed);
    if (eb) chk("cmp_src1_rob", {28'b0, src1_rob_id}, {28'b0, er});
    expect_lookup(src2_arf_id, eb, er, ed);
    chk("cmp_src2_busy", {31'b0, src2_busy}, {31'b0, eb});
    chk("cmp_src2_data", src2_data, ed);
    if (eb) chk("cmp_src2_rob", {28'b0, src2_rob_id}, {28'b0, er});
  end

  // driver tasks
  task automatic idle();
    dispatch_valid = 0; dispatch_ready = 1; dispatch_dst_valid = 0;
    dispatch_dst_arf_id = 0; dispatch_rob_id = 0;
    src1_arf_id = 0; src2_arf_id = 0;
    retire = 0; retire_rob_id = 0; retire_arf_id = 0; retire_reg_data = 0; flush = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1; idle();
  endtask

  task automatic dispatch(input logic [AW-1:0] dst, input logic [RW-1:0] rob);
    dispatch_valid = 1; dispatch_dst_valid = 1; dispatch_dst_arf_id = dst; dispatch_rob_id = rob;
  endtask

  task automatic do_retire(input logic [RW-1:0] rob, input logic [AW-1:0] id, input logic [DW-1:0] d);
    retire = 1; retire_rob_id = rob; retire_arf_id = id; retire_reg_data = d;
  endtask

  task automatic lit(input string name, input logic b, input logic [RW-1:0] r, input logic [DW-1:0] d);
    @(negedge clk);
    chk({name, "_busy"}, {31'b0, src1_busy}, {31'b0, b});
    if (b) chk({name, "_rob"}, {28'b0, src1_rob_id}, {28'b0, r});
    chk({name, "_data"}, src1_data, d);
  endtask

  initial begin
    idle();
    src1_arf_id = 5;
    @(negedge clk);
    chk("reset_x5_data", src1_data, 32'h0);
    chk("reset_x5_busy", {31'b0, src1_busy}, 32'h0);
    @(posedge clk); #1; rst_aH = 0;

    src1_arf_id = 5; src2_arf_id = 0; do_retire(0, 0, 32'hDEAD);
    lit("x5_after_reset", 0, 0, 0);
    next_cycle(); src1_arf_id = 0;
    lit("x0_hardwired", 0, 0, 0);

    // rename x3 then retire with bypass
    next_cycle(); dispatch(3, 2);
    next_cycle(); src1_arf_id = 3;
    lit("x3_renamed", 1, 2, 0);
    next_cycle(); src1_arf_id = 3; do_retire(2, 3, 32'h1234);
    lit("x3_bypass", 0, 0, 32'h1234);
    next_cycle(); src1_arf_id = 3;
    lit("x3_committed", 0, 0, 32'h1234);

    // two producers of x4: the older retire must not clear the rename
    next_cycle(); dispatch(4, 1);
    next_cycle(); dispatch(4, 3);
    next_cycle(); src1_arf_id = 4; do_retire(1, 4, 32'hAA);
    lit("x4_old_retire_nobypass", 1, 3, 0);
    next_cycle(); src1_arf_id = 4;
    lit("x4_still_busy", 1, 3, 32'hAA);
    next_cycle(); do_retire(3, 4, 32'hBB);
    next_cycle(); src1_arf_id = 4;
    lit("x4_young_retired", 0, 0, 32'hBB);

    // same-cycle rename and retire of x6: dispatch wins
    next_cycle(); dispatch(6, 5);
    next_cycle(); dispatch(6, 7); do_retire(5, 6, 32'h55);
    next_cycle(); src1_arf_id = 6;
    lit("x6_dispatch_wins", 1, 7, 32'h55);

    // lookup sees pre-dispatch state; ready=0 does not rename
    next_cycle(); do_retire(0, 1, 32'h11);
    next_cycle(); dispatch(1, 4); src1_arf_id = 1;
    lit("x1_pre_dispatch", 0, 0, 32'h11);
    next_cycle(); src1_arf_id = 1;
    lit("x1_renamed", 1, 4, 32'h11);
    next_cycle(); dispatch(2, 6); dispatch_ready = 0;
    next_cycle(); src1_arf_id = 2;
    lit("x2_not_ready", 0, 0, 0);

    // flush with same-cycle dispatch and retire
    next_cycle(); dispatch(7, 8);
    next_cycle(); dispatch(8, 9);
    next_cycle(); dispatch(9, 10); do_retire(8, 7, 32'h77); flush = 1;
    next_cycle(); src1_arf_id = 7; src2_arf_id = 8;
    lit("x7_flushed", 0, 0, 32'h77);
    @(negedge clk);
    chk("x8_flushed_busy", {31'b0, src2_busy}, 32'h0);
    next_cycle(); src1_arf_id = 9;
    lit("x9_dispatch_discarded", 0, 0, 0);

    // asynchronous reset between edges
    next_cycle(); dispatch(10, 11); src1_arf_id = 3; src2_arf_id = 4;
    lit("x3_before_rst", 0, 0, 32'h1234);
    #2; rst_aH = 1; #1;
    chk("async_rst_src1", src1_data, 32'h0);
    chk("async_rst_src2", src2_data, 32'h0);
    next_cycle(); rst_aH = 0; src1_arf_id = 10; src2_arf_id = 6;
    lit("x10_after_rst", 0, 0, 0);
    @(negedge clk);
    chk("x6_after_rst_busy", {31'b0, src2_busy}, 32'h0);
    next_cycle();
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
